// File: rtl/fft8_frame_sequencer.sv
// rtl/fft8_frame_sequencer.sv - serial-to-parallel frame sequencer around the 8-point butterfly core
// Optional in_last framing check and sticky err_frame enabled by FFT_SEQ_LASTCHK_EN.
module fft8_frame_sequencer #(
  parameter int DW       = 8,
  parameter int PIPE_LAT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DW-1:0]   in_data,
  input  logic            in_valid,
  output logic            in_ready,
`ifdef FFT_SEQ_LASTCHK_EN
  input  logic            in_last,
  output logic            err_frame,
`endif
  output logic [8*DW-1:0] bf_x,
  output logic            bf_start,
  input  logic [8*DW-1:0] bf_X,
  output logic [DW-1:0]   out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic            busy,
  output logic            frame_done,
  output logic [7:0]      frame_cnt
);

  typedef enum logic [1:0] {S_FILL, S_LAUNCH, S_WAIT, S_DRAIN} state_t;

  localparam logic [3:0] LAT = 4'(PIPE_LAT);

  state_t          state_q;
  logic [2:0]      in_cnt_q;
  logic [2:0]      out_cnt_q;
  logic [3:0]      wait_cnt_q;
  logic [7:0]      frame_cnt_q;
  logic            frame_done_q;
  logic            bf_start_q;
  logic            out_valid_q;
  logic            out_last_q;
  logic [DW-1:0]   samp_q [8];
  logic [DW-1:0]   res_q  [8];
  logic            in_xfer;
  logic            early_last;

  assign in_ready   = (state_q == S_FILL) && !reset;
  assign in_xfer    = in_valid && in_ready;
  assign bf_start   = bf_start_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign out_data   = res_q[out_cnt_q];
  assign busy       = (state_q != S_FILL) || (in_cnt_q != 3'd0);
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

  for (genvar k = 0; k < 8; k++) begin : g_bf_x
    assign bf_x[DW*k +: DW] = samp_q[k];
  end

`ifdef FFT_SEQ_LASTCHK_EN
  logic err_q;
  assign early_last = in_last && (in_cnt_q != 3'd7);
  assign err_frame  = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (in_xfer && (early_last || ((in_cnt_q == 3'd7) && !in_last))) begin
      err_q <= 1'b1;
    end
  end
`else
  assign early_last = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FILL;
      in_cnt_q     <= 3'd0;
      out_cnt_q    <= 3'd0;
      wait_cnt_q   <= 4'd0;
      frame_cnt_q  <= 8'd0;
      frame_done_q <= 1'b0;
      bf_start_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        samp_q[k] <= '0;
        res_q[k]  <= '0;
      end
    end else begin
      frame_done_q <= 1'b0;
      bf_start_q   <= 1'b0;
      case (state_q)
        S_FILL: begin
          if (in_xfer) begin
            samp_q[in_cnt_q] <= in_data;
            if (early_last) begin
              in_cnt_q <= 3'd0;
            end else if (in_cnt_q == 3'd7) begin
              in_cnt_q   <= 3'd0;
              state_q    <= S_LAUNCH;
              bf_start_q <= 1'b1;
            end else begin
              in_cnt_q <= in_cnt_q + 3'd1;
            end
          end
        end
        S_LAUNCH: begin
          wait_cnt_q <= LAT;
          // Zero-latency core: its result is already on bf_X during the start pulse.
          if (PIPE_LAT == 0) begin
            for (int k = 0; k < 8; k++) res_q[k] <= bf_X[DW*k +: DW];
            state_q     <= S_DRAIN;
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          wait_cnt_q <= wait_cnt_q - 4'd1;
          if (wait_cnt_q == 4'd1) begin
            for (int k = 0; k < 8; k++) res_q[k] <= bf_X[DW*k +: DW];
            state_q     <= S_DRAIN;
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            out_cnt_q  <= out_cnt_q + 3'd1;
            out_last_q <= (out_cnt_q == 3'd6);
            if (out_cnt_q == 3'd7) begin
              out_cnt_q    <= 3'd0;
              state_q      <= S_FILL;
              out_valid_q  <= 1'b0;
              frame_done_q <= 1'b1;
              frame_cnt_q  <= frame_cnt_q + 8'd1;
            end
          end
        end
        default: state_q <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fft8_frame_sequencer.sv
// tb/tb_fft8_frame_sequencer.sv - scoreboard bench for fft8_frame_sequencer with a delayed XOR butterfly stub
module tb_fft8_frame_sequencer;
  localparam int DW = 8;
  parameter int PIPE_LAT = 1;
  localparam int SIDX = (PIPE_LAT == 0) ? 0 : PIPE_LAT - 1;

  logic            clk;
  logic            reset;
  logic [DW-1:0]   in_data;
  logic            in_valid;
  logic            in_ready;
  logic [8*DW-1:0] bf_x;
  logic            bf_start;
  logic [8*DW-1:0] bf_X;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic            busy;
  logic            frame_done;
  logic [7:0]      frame_cnt;
`ifdef FFT_SEQ_LASTCHK_EN
  logic            in_last;
  logic            err_frame;
`endif

  fft8_frame_sequencer #(.DW(DW), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
`ifdef FFT_SEQ_LASTCHK_EN
    .in_last(in_last), .err_frame(err_frame),
`endif
    .bf_x(bf_x), .bf_start(bf_start), .bf_X(bf_X),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Butterfly stub: result is only meaningful PIPE_LAT cycles after bf_start, zero otherwise.
  logic [8*DW-1:0] stub_now;
  logic [8*DW-1:0] stub_pipe [16];
  assign stub_now = bf_start ? (bf_x ^ {8{8'hFF}}) : '0;
  always @(posedge clk) begin
    stub_pipe[0] <= stub_now;
    for (int i = 1; i < 16; i++) stub_pipe[i] <= stub_pipe[i-1];
  end
  assign bf_X = (PIPE_LAT == 0) ? stub_now : stub_pipe[SIDX];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic finish_tb();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  endtask

  typedef struct packed {logic [7:0] d; logic l;} exp_t;
  exp_t sb_q[$];
  int   exp_frames = 0;

  // Monitor state: input accept tracking, output pops, frame completion.
  int         cyc = 0;
  int         acc_cnt = 0;
  logic [7:0] acc_buf [8];
  int         exp_start_cyc = -1;
  int         out_idx = 0;
  int         stall_cycles = 0;
  bit         expect_done = 0;
  int         done_cyc_q[$];

  always @(negedge clk) begin
    logic [63:0] packed_in;
    exp_t e;
    cyc++;
    if (reset) begin
      acc_cnt = 0;
      exp_start_cyc = -1;
      out_idx = 0;
      expect_done = 0;
    end else begin
      if (bf_start) begin
        for (int k = 0; k < 8; k++) packed_in[8*k +: 8] = acc_buf[k];
        chk("bf_start_cycle", 64'(cyc), 64'(exp_start_cyc));
        chk("bf_x_frame", bf_x, packed_in);
        chk("in_ready_launch", in_ready, 1'b0);
        exp_start_cyc = -1;
      end
      if (expect_done) begin
        chk("frame_done", frame_done, 1'b1);
        chk("frame_cnt", frame_cnt, 8'(exp_frames));
        done_cyc_q.push_back(cyc);
        expect_done = 0;
      end else if (frame_done) begin
        chk("frame_done_spurious", frame_done, 1'b0);
      end
      if (in_valid && in_ready) begin
        acc_buf[acc_cnt] = in_data;
`ifdef FFT_SEQ_LASTCHK_EN
        if (in_last && acc_cnt != 7) acc_cnt = -1;
`endif
        acc_cnt++;
        if (acc_cnt == 8) begin
          acc_cnt = 0;
          exp_start_cyc = cyc + 1;
        end
      end
      if (out_valid) begin
        chk("in_ready_drain", in_ready, 1'b0);
        if (sb_q.size() == 0) begin
          chk("unexpected_output", 1'b1, 1'b0);
        end else if (out_ready) begin
          e = sb_q.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_last", out_last, e.l);
          if (e.l) begin
            exp_frames = (exp_frames + 1) & 255;
            expect_done = 1;
            out_idx = 0;
          end else begin
            out_idx++;
          end
        end else begin
          chk("hold_data", out_data, sb_q[0].d);
          stall_cycles++;
        end
      end
    end
  end

  // Sink: 0 always ready, 1 random, 2 one 5-cycle stall at result 3.
  int rdy_mode = 0;
  int stall_left = 0;
  bit stalled = 0;
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: out_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else if (!stalled && out_idx == 3 && out_valid) begin
            out_ready = 1'b0;
            stall_left = 4;
            stalled = 1;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'b1;
      endcase
    end
  end

  logic [7:0] fr [8];

  task automatic send(input int n, input int last_at, input bit gaps, input bit push);
    int g;
    int t;
    exp_t e;
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        g = $urandom_range(0, 3);
        repeat (g) begin
          in_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_data = fr[k];
`ifdef FFT_SEQ_LASTCHK_EN
      in_last = (k == last_at);
`endif
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!in_ready && t < 300);
      if (!in_ready) begin
        chk("accept_timeout", 1'b0, 1'b1);
        finish_tb();
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
`ifdef FFT_SEQ_LASTCHK_EN
    in_last = 1'b0;
`endif
    if (push && n == 8) begin
      for (int k = 0; k < 8; k++) begin
        e.d = fr[k] ^ 8'hFF;
        e.l = (k == 7);
        sb_q.push_back(e);
      end
    end
    if (last_at < -1) $display("note: last_at %0d", last_at);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("drain_left", 64'(sb_q.size()), 64'd0);
    if (sb_q.size() != 0) finish_tb();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    sb_q.delete();
    exp_frames = 0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_bf_start", bf_start, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_frame_cnt", frame_cnt, 8'd0);
    chk("rst_bf_x", bf_x, 64'd0);
`ifdef FFT_SEQ_LASTCHK_EN
    chk("rst_err_frame", err_frame, 1'b0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_frame();
    for (int k = 0; k < 8; k++) fr[k] = 8'($urandom);
  endtask

  initial begin
    int t;
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
`ifdef FFT_SEQ_LASTCHK_EN
    in_last = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Basic frame 0x01..0x08.
    rdy_mode = 0;
    for (int k = 0; k < 8; k++) fr[k] = 8'(k + 1);
    send(8, 7, 0, 1);
    wait_drain();

    // Five-cycle output stall while result 3 (0xFB) is presented.
    stall_cycles = 0;
    stalled = 0;
    rdy_mode = 2;
    send(8, 7, 0, 1);
    wait_drain();
    chk("stall_cycles", 64'(stall_cycles), 64'd5);

    // Gappy input with random sink.
    rdy_mode = 1;
    rand_frame();
    send(8, 7, 1, 1);
    wait_drain();

    // Back-to-back frames at full rate: period 17 + PIPE_LAT.
    rdy_mode = 0;
    done_cyc_q.delete();
    rand_frame();
    send(8, 7, 0, 1);
    rand_frame();
    send(8, 7, 0, 1);
    wait_drain();
    if (done_cyc_q.size() >= 2) chk("frame_period", 64'(done_cyc_q[1] - done_cyc_q[0]), 64'(17 + PIPE_LAT));
    else chk("frame_period_count", 64'(done_cyc_q.size()), 64'd2);

    // Reset right after launch (WAIT for PIPE_LAT >= 1).
    rand_frame();
    send(8, 7, 0, 0);
    t = 0;
    while (!bf_start && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("launch_seen", bf_start, 1'b1);
    @(posedge clk);
    #1;
    do_reset();

    // Reset after four accepts in FILL.
    rand_frame();
    send(4, -1, 0, 0);
    do_reset();

    // Clean frame after resets, then a random soak.
    rdy_mode = 1;
    for (int f = 0; f < 7; f++) begin
      rand_frame();
      send(8, 7, f != 0, 1);
      if (f == 0) wait_drain();
    end
    wait_drain();

`ifdef FFT_SEQ_LASTCHK_EN
    rdy_mode = 0;
    rand_frame();
    send(5, 4, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("err_early_last", err_frame, 1'b1);
    chk("busy_after_discard", busy, 1'b0);
    rand_frame();
    send(8, 7, 0, 1);
    wait_drain();
    chk("err_sticky", err_frame, 1'b1);
`endif

    finish_tb();
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", n_chk);
    $fatal(1);
  end

endmodule
